axis_latency_monitor: RTL and testbench
=======================================

AXIS_LATENCY_MONITOR -- requirements
Module: axis_latency_monitor

Interface
REQ-001 The block SHALL have the following parameters:
- TDATA_WIDTH, 32, AXIS data width; even and at least 8.
- TDEST_WIDTH, 2, AXIS destination width.
- TID_WIDTH, 2, AXIS source-ID width; NSRC = 2**TID_WIDTH.
- COUNT_WIDTH, 16, width of the packet counters.
- SUM_WIDTH, 32, width of the latency accumulator.
- TDEST, 0, local endpoint address.
- STALL_SEED, 16'hACE1, LFSR seed for backpressure.
- STALL_EN, 0, enables random backpressure when set to 1.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- ticks, in, TDATA_WIDTH/2, free-running time base.
- clear, in, 1, synchronous statistics clear.
- axis_in_tvalid, in, 1, AXIS valid.
- axis_in_tready, out, 1, AXIS ready.
- axis_in_tdata, in, TDATA_WIDTH, AXIS data.
- axis_in_tlast, in, 1, AXIS last beat.
- axis_in_tid, in, TID_WIDTH, source ID.
- axis_in_tdest, in, TDEST_WIDTH, destination.
- recv_packets, out, [NSRC][COUNT_WIDTH], packets received per source.
- lat_min, out, TDATA_WIDTH/2, minimum packet latency.
- lat_max, out, TDATA_WIDTH/2, maximum packet latency.
- lat_sum, out, SUM_WIDTH, total of all packet latencies.
- error, out, 1, sticky error flag.
- error_code, out, 3, code of the first error.

Function
REQ-003 Each beat SHALL be accepted only when axis_in_tvalid and axis_in_tready are both 1 in the same cycle.
REQ-004 When STALL_EN=0, axis_in_tready SHALL be 1 in every cycle after reset.
REQ-005 When STALL_EN=1, axis_in_tready SHALL equal bit 0 of a 16-bit Fibonacci LFSR with taps 16,14,13,11.
- The LFSR loads STALL_SEED at reset.
- The LFSR advances every cycle.
REQ-006 The first beat of a packet SHALL be decoded as follows:
- tdata[TDATA_WIDTH-1:TDATA_WIDTH/2] is the injection timestamp.
- tdata[TDATA_WIDTH/2-1:0] is the per-source sequence number.
REQ-007 The FSM SHALL have three states: IDLE, BODY and ERR.
- IDLE + accepted beat with tlast=1 → IDLE; the packet completes.
- IDLE + accepted beat with tlast=0 → BODY; tid and timestamp are latched.
- BODY + accepted beat with tlast=1 → IDLE; the packet completes.
- Any detected error → ERR; ERR is absorbing until reset.
REQ-008 On every accepted beat, the block SHALL raise error code 1 if tdest ≠ TDEST.
REQ-009 On a BODY beat, the block SHALL raise error code 2 if tid differs from the latched tid.
REQ-010 On a first beat, the block SHALL raise error code 3 if the sequence number ≠ expected_seq[tid].
- expected_seq[tid] starts at 0.
- expected_seq[tid] increments by 1 on each completed packet from that source.
- expected_seq[tid] wraps modulo 2**(TDATA_WIDTH/2).
REQ-011 On packet completion, latency SHALL equal ticks − timestamp, modulo 2**(TDATA_WIDTH/2).
- ticks is sampled in the tlast acceptance cycle.
REQ-012 One cycle after completion, the statistics SHALL update as follows:
- recv_packets[tid] increments and saturates at all-ones.
- lat_min = min(lat_min, latency).
- lat_max = max(lat_max, latency).
- lat_sum += latency and saturates at all-ones.
REQ-013 error and error_code SHALL be registered, visible one cycle after the offending beat.
- error_code keeps the first error only.
- If several errors occur on the same beat, the lowest code is recorded.
REQ-014 In ERR the block SHALL behave as follows:
- axis_in_tready stays 1 so that the upstream drains.
- Beats are discarded.
- Statistics freeze.
REQ-015 When clear=1, the block SHALL restore all statistics to their reset values at the next edge.
- clear does not affect the FSM, expected_seq, the LFSR or error.
- If clear and a completion occur in the same cycle, clear wins and the packet is not counted.

Reset
REQ-016 When rst_n=0 at a clk edge, the block SHALL set the following reset values:
- FSM = IDLE.
- axis_in_tready = 0.
- recv_packets = 0.
- lat_min = all-ones.
- lat_max = 0.
- lat_sum = 0.
- expected_seq = 0.
- error = 0.
- error_code = 0.
- LFSR = STALL_SEED.
REQ-017 Reset SHALL take priority over clear and over every handshake.
REQ-018 A packet that is mid-flight during reset SHALL be discarded without being counted.
REQ-019 axis_in_tready SHALL first reach its active value in the first cycle after rst_n rises.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single-beat packet: tid=1, tdest=TDEST, tdata={16'd100, 16'd0}, accepted at ticks=130 → recv_packets[1]=1, lat_min=lat_max=30, lat_sum=30, error=0.
- Three-beat packet: tid=2, timestamp 0xFFF0, tlast accepted at ticks=0x0010 → latency 0x20 (wrap), recv_packets[2]=1.
- Sequence error: two packets from tid=0, both with seq 0 → error=1, error_code=3 one cycle after the second first beat; later packets not counted; tready remains 1.
- Mixed tid mid-packet: first beat tid=1 (tlast=0), second beat tid=3 → error_code=2.
- If that beat also has a wrong tdest → error_code=1.
- clear asserted on the tlast cycle of a packet → recv_packets=0, lat_min=0xFFFF, lat_sum=0, next expected seq for that source = 1.
- STALL_EN=1, valid held high for 64 cycles → accepted beats equal the tready-high cycles of the LFSR sequence; rst_n pulsed mid-packet → all statistics at reset values and FSM IDLE.

Source files
------------

// File: rtl/axis_latency_monitor.sv
// AXI-Stream sink that checks packet framing and per-source sequence numbers.
// It also gathers per-source packet counts and min/max/sum latency statistics.
module axis_latency_monitor #(
   parameter int              TDATA_WIDTH = 32,
   parameter int              TDEST_WIDTH = 2,
   parameter int              TID_WIDTH   = 2,
   parameter int              COUNT_WIDTH = 16,
   parameter int              SUM_WIDTH   = 32,
   parameter int              TDEST       = 0,
   parameter logic [15:0]     STALL_SEED  = 16'hACE1,
   parameter bit              STALL_EN    = 1'b0
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [TDATA_WIDTH/2-1:0]                     ticks,
   input  logic                                         clear,
   input  logic                                         axis_in_tvalid,
   output logic                                         axis_in_tready,
   input  logic [TDATA_WIDTH-1:0]                       axis_in_tdata,
   input  logic                                         axis_in_tlast,
   input  logic [TID_WIDTH-1:0]                         axis_in_tid,
   input  logic [TDEST_WIDTH-1:0]                       axis_in_tdest,
   output logic [2**TID_WIDTH-1:0][COUNT_WIDTH-1:0]     recv_packets,
   output logic [TDATA_WIDTH/2-1:0]                     lat_min,
   output logic [TDATA_WIDTH/2-1:0]                     lat_max,
   output logic [SUM_WIDTH-1:0]                         lat_sum,
   output logic                                         error,
   output logic [2:0]                                   error_code
);

   // state | meaning
   // IDLE  | waiting for the first beat of a packet
   // BODY  | mid-packet; tid and timestamp latched from the first beat
   // ERR   | protocol error seen; drain and discard until reset

   localparam int HW   = TDATA_WIDTH / 2;
   localparam int NSRC = 2**TID_WIDTH;

   typedef enum logic [1:0] {IDLE, BODY, ERR} state_t;

   state_t                 state, state_next;
   logic                   active;
   logic [15:0]            lfsr;
   logic [TID_WIDTH-1:0]   tid_q;
   logic [HW-1:0]          ts_q;
   logic [HW-1:0]          exp_seq [NSRC];

   logic                   accept, first, err_dest, err_tid, err_seq, any_err, complete;
   logic [2:0]             code_next;
   logic [TID_WIDTH-1:0]   cur_tid;
   logic [HW-1:0]          cur_ts, lat_next;

   logic                   comp_valid;
   logic [TID_WIDTH-1:0]   comp_tid;
   logic [HW-1:0]          comp_lat;
   logic [SUM_WIDTH:0]     sum_ext;

   // In ERR the upstream must be able to drain regardless of the stall pattern.
   assign axis_in_tready = active & ((state == ERR) | !STALL_EN | lfsr[0]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr   <= STALL_SEED;
         active <= 1'b0;
      end else begin
         lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         active <= 1'b1;
      end
   end

   always_comb begin
      accept     = axis_in_tvalid & axis_in_tready;
      first      = (state == IDLE);
      cur_tid    = first ? axis_in_tid : tid_q;
      cur_ts     = first ? axis_in_tdata[TDATA_WIDTH-1:HW] : ts_q;
      lat_next   = ticks - cur_ts;
      err_dest   = accept && (state != ERR) && (axis_in_tdest != TDEST_WIDTH'(TDEST));
      err_tid    = accept && (state == BODY) && (axis_in_tid != tid_q);
      err_seq    = accept && first && (axis_in_tdata[HW-1:0] != exp_seq[axis_in_tid]);
      any_err    = err_dest | err_tid | err_seq;
      complete   = accept && (state != ERR) && axis_in_tlast && !any_err;
      code_next  = 3'd0;
      if (err_dest)     code_next = 3'd1;
      else if (err_tid) code_next = 3'd2;
      else if (err_seq) code_next = 3'd3;
      state_next = state;
      case (state)
         IDLE: begin
            if (any_err)                      state_next = ERR;
            else if (accept && !axis_in_tlast) state_next = BODY;
         end
         BODY: begin
            if (any_err)                      state_next = ERR;
            else if (accept && axis_in_tlast)  state_next = IDLE;
         end
         ERR:     state_next = ERR;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         tid_q      <= '0;
         ts_q       <= '0;
         comp_valid <= 1'b0;
         comp_tid   <= '0;
         comp_lat   <= '0;
         error      <= 1'b0;
         error_code <= 3'd0;
         for (int i = 0; i < NSRC; i++) exp_seq[i] <= '0;
      end else begin
         state <= state_next;
         if (first && accept && state_next == BODY) begin
            tid_q <= axis_in_tid;
            ts_q  <= axis_in_tdata[TDATA_WIDTH-1:HW];
         end
         if (complete) exp_seq[cur_tid] <= exp_seq[cur_tid] + 1'b1;
         // A clear coinciding with completion drops the packet from the stats.
         comp_valid <= complete & ~clear;
         comp_tid   <= cur_tid;
         comp_lat   <= lat_next;
         if (any_err && !error) begin
            error      <= 1'b1;
            error_code <= code_next;
         end
      end
   end

   assign sum_ext = {1'b0, lat_sum} + {{(SUM_WIDTH + 1 - HW){1'b0}}, comp_lat};

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         recv_packets <= '0;
         lat_min      <= '1;
         lat_max      <= '0;
         lat_sum      <= '0;
      end else if (comp_valid) begin
         if (recv_packets[comp_tid] != '1)
            recv_packets[comp_tid] <= recv_packets[comp_tid] + 1'b1;
         if (comp_lat < lat_min) lat_min <= comp_lat;
         if (comp_lat > lat_max) lat_max <= comp_lat;
         lat_sum <= sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_axis_latency_monitor.sv
// Directed bench for axis_latency_monitor: one always-ready instance and one
// instance with LFSR backpressure, checked against hand-computed values.
module tb_axis_latency_monitor;

   logic              clk = 1'b0;
   logic              rst_n, clear, valid, tlast;
   logic [31:0]       tdata;
   logic [1:0]        tid, tdest;
   logic [15:0]       ticks;
   logic              tready, error;
   logic [2:0]        error_code;
   logic [3:0][15:0]  recv;
   logic [15:0]       lat_min, lat_max;
   logic [31:0]       lat_sum;

   logic              rst_n_s, valid_s, tlast_s, tready_s, error_s;
   logic [31:0]       tdata_s;
   logic [1:0]        tid_s;
   logic [2:0]        error_code_s;
   logic [3:0][15:0]  recv_s;
   logic [15:0]       lat_min_s, lat_max_s;
   logic [31:0]       lat_sum_s;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] m;

   always #5 clk = ~clk;

   axis_latency_monitor dut (
      .clk(clk), .rst_n(rst_n), .ticks(ticks), .clear(clear),
      .axis_in_tvalid(valid), .axis_in_tready(tready), .axis_in_tdata(tdata),
      .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
      .recv_packets(recv), .lat_min(lat_min), .lat_max(lat_max),
      .lat_sum(lat_sum), .error(error), .error_code(error_code)
   );

   axis_latency_monitor #(.STALL_EN(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n_s), .ticks(ticks), .clear(1'b0),
      .axis_in_tvalid(valid_s), .axis_in_tready(tready_s), .axis_in_tdata(tdata_s),
      .axis_in_tlast(tlast_s), .axis_in_tid(tid_s), .axis_in_tdest(2'd0),
      .recv_packets(recv_s), .lat_min(lat_min_s), .lat_max(lat_max_s),
      .lat_sum(lat_sum_s), .error(error_s), .error_code(error_code_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // One beat on the always-ready instance; returns #1 after the accepting edge.
   task automatic send(input logic [1:0] t, input logic [1:0] d, input logic [15:0] ts,
                       input logic [15:0] seq, input logic last, input logic [15:0] tk,
                       input logic clr = 1'b0);
      tid = t; tdest = d; tdata = {ts, seq}; tlast = last; ticks = tk; clear = clr;
      valid = 1'b1;
      tick();
      valid = 1'b0; tlast = 1'b0; clear = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; valid = 1'b0; tlast = 1'b0; tdata = '0;
      tid = '0; tdest = '0; ticks = '0;
      rst_n_s = 1'b0; valid_s = 1'b0; tlast_s = 1'b0; tdata_s = '0; tid_s = '0;
      repeat (3) tick();
      check_eq("rst_tready", tready, 0);
      check_eq("rst_recv1", recv[1], 0);
      check_eq("rst_min", lat_min, 16'hFFFF);
      check_eq("rst_max", lat_max, 0);
      check_eq("rst_sum", lat_sum, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_code", error_code, 0);
      rst_n = 1'b1;
      tick();
      check_eq("tready_after_rst", tready, 1);

      // single-beat packet, latency 130-100
      send(2'd1, 2'd0, 16'd100, 16'd0, 1'b1, 16'd130);
      check_eq("single_err", error, 0);
      tick();
      check_eq("single_recv1", recv[1], 1);
      check_eq("single_min", lat_min, 30);
      check_eq("single_max", lat_max, 30);
      check_eq("single_sum", lat_sum, 30);

      // three-beat packet with timestamp wrap: 0x0010 - 0xFFF0 = 0x20
      send(2'd2, 2'd0, 16'hFFF0, 16'd0, 1'b0, 16'd0);
      send(2'd2, 2'd0, 16'h5555, 16'h1234, 1'b0, 16'd5);
      send(2'd2, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'h0010);
      tick();
      check_eq("three_recv2", recv[2], 1);
      check_eq("three_max", lat_max, 16'h20);
      check_eq("three_min", lat_min, 30);
      check_eq("three_sum", lat_sum, 62);

      // clear on the completing beat: stats wiped, seq for tid1 still advances
      send(2'd1, 2'd0, 16'd10, 16'd1, 1'b1, 16'd15, 1'b1);
      tick();
      check_eq("clr_recv1", recv[1], 0);
      check_eq("clr_recv2", recv[2], 0);
      check_eq("clr_min", lat_min, 16'hFFFF);
      check_eq("clr_max", lat_max, 0);
      check_eq("clr_sum", lat_sum, 0);
      send(2'd1, 2'd0, 16'd10, 16'd2, 1'b1, 16'd15);
      check_eq("clr_seq_err", error, 0);
      tick();
      check_eq("clr_next_recv1", recv[1], 1);
      check_eq("clr_next_sum", lat_sum, 5);

      // reset while mid-packet: nothing counted, expected_seq back to 0
      send(2'd0, 2'd0, 16'd50, 16'd0, 1'b0, 16'd60);
      rst_n = 1'b0;
      tick();
      check_eq("mid_rst_recv1", recv[1], 0);
      check_eq("mid_rst_min", lat_min, 16'hFFFF);
      check_eq("mid_rst_sum", lat_sum, 0);
      rst_n = 1'b1;
      tick();
      send(2'd1, 2'd0, 16'd200, 16'd0, 1'b1, 16'd210);
      check_eq("mid_rst_seq_err", error, 0);
      tick();
      check_eq("mid_rst_recv0", recv[0], 0);
      check_eq("mid_rst_recv1b", recv[1], 1);
      check_eq("mid_rst_lat", lat_min, 10);

      // repeated sequence number from tid0
      send(2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 16'd3);
      check_eq("seq_first_err", error, 0);
      send(2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 16'd4);
      check_eq("seq_error", error, 1);
      check_eq("seq_code", error_code, 3);
      check_eq("seq_tready", tready, 1);
      send(2'd0, 2'd0, 16'd0, 16'd1, 1'b1, 16'd9);
      tick();
      check_eq("seq_recv0_frozen", recv[0], 1);
      check_eq("seq_sum_frozen", lat_sum, 13);
      check_eq("seq_min_frozen", lat_min, 3);
      check_eq("seq_tready_err", tready, 1);

      // tid change mid-packet; later errors do not overwrite the first code
      do_reset();
      send(2'd1, 2'd0, 16'd0, 16'd0, 1'b0, 16'd0);
      send(2'd3, 2'd0, 16'd0, 16'd0, 1'b0, 16'd1);
      check_eq("tid_error", error, 1);
      check_eq("tid_code", error_code, 2);
      send(2'd3, 2'd1, 16'd0, 16'd0, 1'b1, 16'd2);
      check_eq("tid_code_kept", error_code, 2);

      // tid change plus wrong tdest on the same beat: lowest code wins
      do_reset();
      check_eq("rst2_error", error, 0);
      send(2'd1, 2'd0, 16'd0, 16'd0, 1'b0, 16'd0);
      send(2'd3, 2'd1, 16'd0, 16'd0, 1'b0, 16'd1);
      check_eq("dest_code", error_code, 1);

      // backpressure instance: tready must follow the LFSR bit 0 sequence
      m = 16'hACE1;
      valid_s = 1'b1; tlast_s = 1'b0; tid_s = 2'd0; tdata_s = '0;
      rst_n_s = 1'b1;
      for (int i = 0; i < 64; i++) begin
         tick();
         m = lfsr_step(m);
         check_eq($sformatf("stall_tready_%0d", i), tready_s, m[0]);
      end
      check_eq("stall_no_err", error_s, 0);
      rst_n_s = 1'b0;
      tick();
      valid_s = 1'b0;
      check_eq("stall_rst_tready", tready_s, 0);
      check_eq("stall_rst_recv0", recv_s[0], 0);
      check_eq("stall_rst_min", lat_min_s, 16'hFFFF);
      check_eq("stall_rst_sum", lat_sum_s, 0);
      rst_n_s = 1'b1;
      tick();
      for (int i = 0; i < 50 && !tready_s; i++) tick();
      check_eq("stall_wait_ready", tready_s, 1);
      // tid differs from the pre-reset latched tid: only clean if FSM is IDLE
      tid_s = 2'd1; tdata_s = {16'd7, 16'd0}; tlast_s = 1'b1; ticks = 16'd9;
      valid_s = 1'b1;
      tick();
      valid_s = 1'b0;
      check_eq("stall_post_err", error_s, 0);
      tick();
      check_eq("stall_post_recv1", recv_s[1], 1);
      check_eq("stall_post_lat", lat_min_s, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
